// File: rtl/text_pkg.sv
// text_pkg: shared constants for the text overlay blocks.
// Char codes, glyph size and write-data fields.
package text_pkg;

  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 5;

  localparam logic [4:0] CH_SPACE = 5'd0;
  localparam logic [4:0] CH_S = 5'd1;
  localparam logic [4:0] CH_T = 5'd2;
  localparam logic [4:0] CH_A = 5'd3;
  localparam logic [4:0] CH_R = 5'd4;
  localparam logic [4:0] CH_H = 5'd5;
  localparam logic [4:0] CH_O = 5'd6;
  localparam logic [4:0] CH_W = 5'd7;
  localparam logic [4:0] CH_P = 5'd8;
  localparam logic [4:0] CH_L = 5'd9;
  localparam logic [4:0] CH_Y = 5'd10;
  localparam logic [4:0] CH_C = 5'd11;
  localparam logic [4:0] CH_E = 5'd12;
  localparam logic [4:0] CH_0 = 5'd13;
  localparam logic [4:0] CH_1 = 5'd14;
  localparam logic [4:0] CH_2 = 5'd15;
  localparam logic [4:0] CH_3 = 5'd16;
  localparam logic [4:0] CH_4 = 5'd17;
  localparam logic [4:0] CH_5 = 5'd18;
  localparam logic [4:0] CH_6 = 5'd19;
  localparam logic [4:0] CH_7 = 5'd20;
  localparam logic [4:0] CH_8 = 5'd21;
  localparam logic [4:0] CH_9 = 5'd22;

  localparam int WR_BLINK_BIT = 5;
  localparam int WR_CODE_MSB = 4;
  localparam int WR_CODE_LSB = 0;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

endpackage

// File: rtl/font_rom_5x5.sv
// font_rom_5x5: combinational 5x5 glyph lookup.
// Out-of-glyph col/row and unused codes give no ink.
module font_rom_5x5
  import text_pkg::*;
(
  input  logic [4:0] code,
  input  logic [2:0] col,
  input  logic [2:0] row,
  output logic       ink
);

  logic [24:0] glyph;
  logic [4:0]  idx;

  // Bitmap per code, MSB is top-left.
  always_comb begin
    glyph = '0;
    unique case (code)
      CH_S: glyph = 25'b01111_10000_01110_00001_11110;
      CH_T: glyph = 25'b11111_00100_00100_00100_00100;
      CH_A: glyph = 25'b01110_10001_11111_10001_10001;
      CH_R: glyph = 25'b11110_10001_11110_10100_10010;
      CH_H: glyph = 25'b10001_10001_11111_10001_10001;
      CH_O: glyph = 25'b01110_10001_10001_10001_01110;
      CH_W: glyph = 25'b10001_10001_10101_10101_01010;
      CH_P: glyph = 25'b11110_10001_11110_10000_10000;
      CH_L: glyph = 25'b10000_10000_10000_10000_11111;
      CH_Y: glyph = 25'b10001_01010_00100_00100_00100;
      CH_C: glyph = 25'b01111_10000_10000_10000_01111;
      CH_E: glyph = 25'b11111_10000_11110_10000_11111;
      CH_0: glyph = 25'b01110_10011_10101_11001_01110;
      CH_1: glyph = 25'b00100_01100_00100_00100_01110;
      CH_2: glyph = 25'b11110_00001_01110_10000_11111;
      CH_3: glyph = 25'b11110_00001_01110_00001_11110;
      CH_4: glyph = 25'b10010_10010_11111_00010_00010;
      CH_5: glyph = 25'b11111_10000_11110_00001_11110;
      CH_6: glyph = 25'b01110_10000_11110_10001_01110;
      CH_7: glyph = 25'b11111_00001_00010_00100_00100;
      CH_8: glyph = 25'b01110_10001_01110_10001_01110;
      CH_9: glyph = 25'b01110_10001_01111_00001_01110;
      default: glyph = '0;
    endcase
  end

  // Pick bit[24 - (row*5 + col)] inside the glyph.
  always_comb begin
    idx = 5'(row) * 5'd5 + 5'(col);
    ink = 1'b0;
    if (col < 3'd5 && row < 3'd5) begin
      ink = glyph[5'd24 - idx];
    end
  end

endmodule

// File: rtl/text_overlay.sv
// text_overlay: writable character window, 3-stage pixel pipe.
// Clear FSM owns the RAM write port while busy.
module text_overlay
  import text_pkg::*;
#(
  parameter int         N_COLS       = 16,
  parameter int         N_ROWS       = 4,
  parameter logic [9:0] ORIGIN_X     = 10'd10,
  parameter logic [9:0] ORIGIN_Y     = 10'd10,
  parameter int         SCALE_LOG2   = 1,
  parameter int         SPACING      = 2,
  parameter int         BLINK_FRAMES = 30,
  localparam int        N_CELLS      = N_COLS * N_ROWS,
  localparam int        AW           = $clog2(N_CELLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  output logic          wr_ready,
  input  logic          clear_req,
  output logic          busy,
  output logic          text_on,
  output logic          text_valid
);

  localparam int CW = GLYPH_W + SPACING;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [9:0] dx, dy, rx, ry;
  logic [9:0] col, row, fc;
  logic       ge_x, ge_y;

  logic          s1_in_box_d, s1_in_box_q;
  logic [AW-1:0] s1_addr_d, s1_addr_q;
  logic [2:0]    s1_fc_d, s1_fc_q;
  logic [2:0]    s1_fr_d, s1_fr_q;
  logic          s1_valid_q;

  logic          s2_valid_q, s2_in_box_q;
  logic [2:0]    s2_fc_q, s2_fr_q;
  logic [5:0]    rd_q;

  logic [5:0]    mem_q [N_CELLS];
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [5:0]    ram_wd;

  clr_state_e    state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;

  logic [FW-1:0] frame_cnt_d, frame_cnt_q;
  logic          blink_phase_d, blink_phase_q;

  logic          ink;
  logic          text_on_d;

  // Map screen x/y to cell address and font col/row.
  always_comb begin
    ge_x = (x >= ORIGIN_X);
    ge_y = (y >= ORIGIN_Y);
    dx = ge_x ? (x - ORIGIN_X) : '0;
    dy = ge_y ? (y - ORIGIN_Y) : '0;
    rx = dx >> SCALE_LOG2;
    ry = dy >> SCALE_LOG2;
    col = rx / 10'(CW);
    fc = rx % 10'(CW);
    row = ry / 10'd5;
    s1_fr_d = 3'(ry % 10'd5);
    s1_in_box_d = ge_x && ge_y
      && (col < 10'(N_COLS))
      && (row < 10'(N_ROWS))
      && (fc < 10'd5);
    s1_addr_d = '0;
    s1_fc_d = '0;
    if (s1_in_box_d) begin
      s1_addr_d = AW'(row) * AW'(N_COLS)
        + AW'(col);
      s1_fc_d = 3'(fc);
    end
  end

  // S1 and S2 pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_in_box_q <= 1'b0;
      s1_addr_q   <= '0;
      s1_fc_q     <= '0;
      s1_fr_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_in_box_q <= 1'b0;
      s2_fc_q     <= '0;
      s2_fr_q     <= '0;
    end else begin
      s1_valid_q  <= pix_valid;
      s1_in_box_q <= s1_in_box_d;
      s1_addr_q   <= s1_addr_d;
      s1_fc_q     <= s1_fc_d;
      s1_fr_q     <= s1_fr_d;
      s2_valid_q  <= s1_valid_q;
      s2_in_box_q <= s1_in_box_q;
      s2_fc_q     <= s1_fc_q;
      s2_fr_q     <= s1_fr_q;
    end
  end

  // Character RAM, read-first on collision.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_wa] <= ram_wd;
    end
    rd_q <= mem_q[s1_addr_q];
  end

  // Clear FSM next state and RAM write mux.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ram_we = 1'b0;
    ram_wa = wr_addr;
    ram_wd = wr_data;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we = 1'b1;
        ram_wa = cnt_q;
        ram_wd = '0;
        if (cnt_q == AW'(N_CELLS - 1)) begin
          state_d = ST_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        ram_we = wr_en;
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame counter and blink phase.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Blink state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  font_rom_5x5 u_font (
    .code (rd_q[WR_CODE_MSB:WR_CODE_LSB]),
    .col  (s2_fc_q),
    .row  (s2_fr_q),
    .ink  (ink)
  );

  // S3 ink with blink mask.
  always_comb begin
    text_on_d = s2_valid_q && s2_in_box_q && ink
      && !(rd_q[WR_BLINK_BIT] && blink_phase_q);
  end

  // S3 output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_on    <= 1'b0;
      text_valid <= 1'b0;
    end else begin
      text_on    <= text_on_d;
      text_valid <= s2_valid_q;
    end
  end

  assign busy = (state_q == ST_CLEAR);
  assign wr_ready = !busy;

endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: random + directed checks against a
// behavioural model of the text window.
module tb_text_overlay;

  localparam int NC = 16;
  localparam int NR = 4;
  localparam int OX = 10;
  localparam int OY = 10;
  localparam int SC = 1;
  localparam int SP = 2;
  localparam int BF = 2;
  localparam int NCELL = NC * NR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       frame_start = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       wr_ready;
  logic       clear_req = 1'b0;
  logic       busy;
  logic       text_on;
  logic       text_valid;

  int n_chk = 0;
  int n_fail = 0;

  text_overlay #(
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid),
    .x(x), .y(y), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_req(clear_req), .busy(busy),
    .text_on(text_on), .text_valid(text_valid)
  );

  always #5 clk = ~clk;

  function automatic bit font_ink(int code, int c, int r);
    logic [24:0] g;
    case (code)
      1:  g = 25'b01111_10000_01110_00001_11110;
      2:  g = 25'b11111_00100_00100_00100_00100;
      3:  g = 25'b01110_10001_11111_10001_10001;
      4:  g = 25'b11110_10001_11110_10100_10010;
      5:  g = 25'b10001_10001_11111_10001_10001;
      6:  g = 25'b01110_10001_10001_10001_01110;
      7:  g = 25'b10001_10001_10101_10101_01010;
      8:  g = 25'b11110_10001_11110_10000_10000;
      9:  g = 25'b10000_10000_10000_10000_11111;
      10: g = 25'b10001_01010_00100_00100_00100;
      11: g = 25'b01111_10000_10000_10000_01111;
      12: g = 25'b11111_10000_11110_10000_11111;
      13: g = 25'b01110_10011_10101_11001_01110;
      14: g = 25'b00100_01100_00100_00100_01110;
      15: g = 25'b11110_00001_01110_10000_11111;
      16: g = 25'b11110_00001_01110_00001_11110;
      17: g = 25'b10010_10010_11111_00010_00010;
      18: g = 25'b11111_10000_11110_00001_11110;
      19: g = 25'b01110_10000_11110_10001_01110;
      20: g = 25'b11111_00001_00010_00100_00100;
      21: g = 25'b01110_10001_01110_10001_01110;
      22: g = 25'b01110_10001_01111_00001_01110;
      default: g = '0;
    endcase
    if (c < 0 || c > 4 || r < 0 || r > 4) return 1'b0;
    return g[24 - (r * 5 + c)];
  endfunction

  task automatic geom(input int px, input int py,
                      output bit inb, output int addr,
                      output int fc, output int fr);
    int rx, ry, col, row;
    inb = 1'b0; addr = 0; fc = 0; fr = 0;
    if (px >= OX && py >= OY) begin
      rx = (px - OX) >> SC;
      ry = (py - OY) >> SC;
      col = rx / (5 + SP);
      fc = rx % (5 + SP);
      row = ry / 5;
      fr = ry % 5;
      inb = (col < NC) && (row < NR) && (fc < 5);
      addr = row * NC + col;
    end
  endtask

  typedef struct {
    bit v;
    bit inb;
    int addr;
    int fc;
    int fr;
    bit [5:0] d;
  } ent_t;

  bit [5:0] mmem [NCELL];
  ent_t p1, p2;
  bit   m_busy = 1'b1;
  int   m_clr = 0;
  int   m_pulses = 0;
  bit   e_on = 1'b0;
  bit   e_val = 1'b0;

  // Behavioural model, stepped on each clock edge.
  initial begin
    p1 = '{default: 0};
    p2 = '{default: 0};
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        p1 = '{default: 0};
        p2 = '{default: 0};
        m_busy = 1'b1; m_clr = 0; m_pulses = 0;
        e_on = 1'b0; e_val = 1'b0;
      end else begin
        bit ph;
        bit inb;
        int a, fc, fr;
        ph = ((m_pulses / BF) % 2) == 1;
        e_val = p2.v;
        e_on = p2.v && p2.inb
          && font_ink(int'(p2.d[4:0]), p2.fc, p2.fr)
          && !(p2.d[5] && ph);
        p2 = p1;
        p2.d = p1.inb ? mmem[p1.addr] : 6'd0;
        geom(int'(x), int'(y), inb, a, fc, fr);
        p1.v = pix_valid; p1.inb = inb;
        p1.addr = a; p1.fc = fc; p1.fr = fr;
        if (m_busy) begin
          mmem[m_clr] = 6'd0;
          m_clr++;
          if (m_clr == NCELL) m_busy = 1'b0;
        end else begin
          if (wr_en) mmem[int'(wr_addr)] = wr_data;
          if (clear_req) begin
            m_busy = 1'b1; m_clr = 0;
          end
        end
        if (frame_start) m_pulses++;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_chk += 4;
        if (busy !== m_busy) begin
          n_fail++;
          $display("FAIL cyc_busy: got %b want %b", busy, m_busy);
        end
        if (wr_ready !== !m_busy) begin
          n_fail++;
          $display("FAIL cyc_wr_ready: got %b want %b",
                   wr_ready, !m_busy);
        end
        if (text_valid !== e_val) begin
          n_fail++;
          $display("FAIL cyc_text_valid: got %b want %b",
                   text_valid, e_val);
        end
        if (text_on !== e_on) begin
          n_fail++;
          $display("FAIL cyc_text_on: got %b want %b @%0t",
                   text_on, e_on, $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wr(input int a, input int d);
    wait_idle();
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_data = 6'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pix_chk(input int px, input int py,
                         input int exp, input string nm);
    pix_valid = 1'b1;
    x = 10'(px);
    y = 10'(py);
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    chk(nm, int'(text_on), exp);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(nm, n, 64);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit inb;
    int a, fc, fr, lit;

    // Pin the model itself with hand-computed values.
    geom(12, 10, inb, a, fc, fr);
    chk("mdl_inb_12_10", int'(inb), 1);
    chk("mdl_fc_12_10", fc, 1);
    chk("mdl_addr_12_10", a, 0);
    geom(220, 40, inb, a, fc, fr);
    chk("mdl_addr_220_40", a, 63);
    chk("mdl_inb_220_40", int'(inb), 1);
    geom(234, 40, inb, a, fc, fr);
    chk("mdl_inb_234_40", int'(inb), 0);
    geom(20, 10, inb, a, fc, fr);
    chk("mdl_inb_20_10", int'(inb), 0);
    chk("mdl_font_S00", int'(font_ink(1, 0, 0)), 0);
    chk("mdl_font_S10", int'(font_ink(1, 1, 0)), 1);
    chk("mdl_font_E00", int'(font_ink(12, 0, 0)), 1);

    repeat (3) tick();
    chk("rst_busy", int'(busy), 1);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_text_on", int'(text_on), 0);
    chk("rst_text_valid", int'(text_valid), 0);
    rst = 1'b0;
    count_busy("reset_clear_len");
    chk("busy_after_clear", int'(busy), 0);

    lit = 0;
    for (int yy = 0; yy < 56; yy++) begin
      for (int xx = 0; xx < 256; xx++) begin
        pix_valid = 1'b1;
        x = 10'(xx);
        y = 10'(yy);
        tick();
        lit += int'(text_on);
      end
    end
    pix_valid = 1'b0;
    repeat (3) begin
      tick();
      lit += int'(text_on);
    end
    chk("scan_dark", lit, 0);

    wr(0, 1);
    pix_chk(10, 10, 0, "basic_S_r0c0");
    pix_chk(12, 10, 1, "basic_S_r0c1");
    pix_chk(20, 10, 0, "basic_spacing");

    wr(63, 12);
    pix_chk(220, 40, 1, "bounds_last_cell");
    pix_chk(234, 40, 0, "bounds_col16");
    pix_chk(9, 10, 0, "bounds_left");

    wr(1, 6'd33);
    for (int f = 0; f < 6; f++) begin
      pix_chk(26, 10, ((f / 2) % 2 == 0) ? 1 : 0,
              "blink_cell");
      pix_chk(12, 10, 1, "steady_cell");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end

    wr(5, 12);
    pix_chk(80, 10, 1, "hs_write_ok");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("hs_busy", int'(busy), 1);
    wr_en = 1'b1;
    wr_addr = 6'd5;
    wr_data = 6'd12;
    repeat (10) begin
      tick();
      chk("hs_wr_ready_low", int'(wr_ready), 0);
    end
    wr_en = 1'b0;
    wait_idle();
    pix_chk(80, 10, 0, "hs_dropped_write");
    chk("hs_idle_ready", int'(wr_ready), 1);
    wr_en = 1'b1;
    clear_req = 1'b1;
    wr_addr = 6'd5;
    wr_data = 6'd12;
    tick();
    wr_en = 1'b0;
    clear_req = 1'b0;
    chk("hs_busy2", int'(busy), 1);
    wait_idle();
    pix_chk(80, 10, 0, "hs_write_then_clear");

    wr(0, 1);
    pix_valid = 1'b1;
    x = 10'd12;
    y = 10'd10;
    tick();
    wr_en = 1'b1;
    wr_addr = 6'd0;
    wr_data = 6'd5;
    tick();
    pix_valid = 1'b0;
    wr_en = 1'b0;
    tick();
    chk("coll_old_glyph", int'(text_on), 1);
    tick();
    chk("coll_new_glyph", int'(text_on), 0);

    for (int i = 0; i < 20000; i++) begin
      pix_valid = ($urandom_range(3) != 0);
      x = 10'($urandom_range(250));
      y = 10'($urandom_range(55));
      wr_en = ($urandom_range(3) == 0);
      wr_addr = 6'($urandom_range(63));
      wr_data = {1'($urandom), 5'($urandom_range(22))};
      clear_req = ($urandom_range(299) == 0);
      frame_start = ($urandom_range(40) == 0);
      tick();
    end
    pix_valid = 1'b0;
    wr_en = 1'b0;
    clear_req = 1'b0;
    frame_start = 1'b0;
    wait_idle();

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_wr_ready", int'(wr_ready), 0);
    chk("midrst_text_valid", int'(text_valid), 0);
    tick();
    rst = 1'b0;
    count_busy("midrst_clear_len");
    pix_chk(12, 10, 0, "midrst_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
